// File: rtl/blake_pkg.sv
// Shared definitions for the BLAKE-256 G datapath.
//   WORD_W          : state word width (32)
//   R16/R12/R8/R7   : G rotation amounts
//   word_t          : one state word
//   rotl32/rotr32   : 32-bit circular rotates (rotate amount taken modulo 32)
package blake_pkg;

  localparam int unsigned WORD_W = 32;

  localparam int unsigned R16 = 16;
  localparam int unsigned R12 = 12;
  localparam int unsigned R8  = 8;
  localparam int unsigned R7  = 7;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t rotl32(input word_t x, input int unsigned n);
    int unsigned s;
    s = n % WORD_W;
    // A zero rotate would otherwise shift right by the full width.
    if (s == 0) begin
      return x;
    end
    return (x << s) | (x >> (WORD_W - s));
  endfunction

  function automatic word_t rotr32(input word_t x, input int unsigned n);
    return rotl32(x, (WORD_W - (n % WORD_W)) % WORD_W);
  endfunction

endpackage

// File: rtl/blake_g_half_inv.sv
// Combinational inverse of one half of the BLAKE-256 G function.
// Given the words after a half-step (a, b, c, d) and the addend m used in that
// half-step, recovers the words before it.
//   RB, RD              : rotate amounts the forward half-step applied to b and d
//   a, b, c, d          : words after the half-step
//   m                   : message/constant addend of the half-step
//   a_out..d_out        : words before the half-step
module blake_g_half_inv
  import blake_pkg::*;
#(
  parameter int unsigned RB = R7,
  parameter int unsigned RD = R8
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  input  logic [WORD_W-1:0] m,
  output logic [WORD_W-1:0] a_out,
  output logic [WORD_W-1:0] b_out,
  output logic [WORD_W-1:0] c_out,
  output logic [WORD_W-1:0] d_out
);

  // Forward half-step: a'=a+b+m; d'=rotr(d^a',RD); c'=c+d'; b'=rotr(b^c',RB).
  // Undo it in reverse order; a needs the recovered b, not the incoming one.
  always_comb begin
    b_out = rotl32(b, RB) ^ c;
    c_out = c - d;
    d_out = rotl32(d, RD) ^ a;
    a_out = a - b_out - m;
  end

endmodule

// File: rtl/blake_g_inverse_piped.sv
// Two-stage pipelined inverse of the BLAKE-256 G function with a valid/ready
// handshake on both sides, so a slow readback consumer can stall it.
//   clk, rst               : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready    : input beat handshake (in_ready is combinational
//                            from out_ready)
//   a_in..d_in             : post-G words a2/b2/c2/d2
//   msg_i, msg_ip          : pre-XORed message/constant addends of the first and
//                            second half of G, presented in the same beat
//   out_valid / out_ready  : output handshake; out_valid and data are registered
//   a_out..d_out           : recovered pre-G words
module blake_g_inverse_piped
  import blake_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] b_in,
  input  logic [WORD_W-1:0] c_in,
  input  logic [WORD_W-1:0] d_in,
  input  logic [WORD_W-1:0] msg_i,
  input  logic [WORD_W-1:0] msg_ip,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] a_out,
  output logic [WORD_W-1:0] b_out,
  output logic [WORD_W-1:0] c_out,
  output logic [WORD_W-1:0] d_out
);

  // Handshake state: one valid bit per stage.
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s1_load;
  logic s2_adv;

  // Stage 1 results (a1..d1) plus the first-half addend travelling alongside.
  word_t s1_a_q, s1_b_q, s1_c_q, s1_d_q, s1_mi_q;
  word_t s1_a_d, s1_b_d, s1_c_d, s1_d_d;

  // Output registers.
  word_t o_a_q, o_b_q, o_c_q, o_d_q;
  word_t o_a_d, o_b_d, o_c_d, o_d_d;

  // Stage 1 undoes the second half of G (b rotate 7, d rotate 8, addend msg_ip).
  blake_g_half_inv #(
    .RB (R7),
    .RD (R8)
  ) u_half_inv_s1 (
    .a     (a_in),
    .b     (b_in),
    .c     (c_in),
    .d     (d_in),
    .m     (msg_ip),
    .a_out (s1_a_d),
    .b_out (s1_b_d),
    .c_out (s1_c_d),
    .d_out (s1_d_d)
  );

  // Stage 2 undoes the first half of G (b rotate 12, d rotate 16, addend msg_i).
  blake_g_half_inv #(
    .RB (R12),
    .RD (R16)
  ) u_half_inv_s2 (
    .a     (s1_a_q),
    .b     (s1_b_q),
    .c     (s1_c_q),
    .d     (s1_d_q),
    .m     (s1_mi_q),
    .a_out (o_a_d),
    .b_out (o_b_d),
    .c_out (o_c_d),
    .d_out (o_d_d)
  );

  // Stage 2 moves when it holds something and the output slot is free or
  // draining this cycle; stage 1 can then take a new beat in the same edge.
  always_comb begin
    s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
    in_ready = ~s1_valid_q | s2_adv;
    s1_load  = in_valid & in_ready;

    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    if (s2_adv) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Data registers only load on a transfer, so stalled stages hold their data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_c_q  <= '0;
      s1_d_q  <= '0;
      s1_mi_q <= '0;
    end else if (s1_load) begin
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_c_q  <= s1_c_d;
      s1_d_q  <= s1_d_d;
      s1_mi_q <= msg_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_a_q <= '0;
      o_b_q <= '0;
      o_c_q <= '0;
      o_d_q <= '0;
    end else if (s2_adv) begin
      o_a_q <= o_a_d;
      o_b_q <= o_b_d;
      o_c_q <= o_c_d;
      o_d_q <= o_d_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a_out     = o_a_q;
  assign b_out     = o_b_q;
  assign c_out     = o_c_q;
  assign d_out     = o_d_q;

endmodule
